// File: rtl/fpcvt_arb.sv
// Round-robin arbiter feeding a shared two-stage 12-bit linear to 8-bit FP converter.
// Stage A captures the granted sample as sign/magnitude/leading-zeros; stage B rounds and packs.
module fpcvt_arb #(
    parameter int NREQ     = 4,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [2:0]           out_exp,
    output logic [3:0]           out_sig,
    output logic [1:0]           out_id,
    output logic                 busy
);

    logic [1:0]  r_ptr;
    logic        r_a_valid;
    logic        r_a_sign;
    logic [10:0] r_a_mag;
    logic [3:0]  r_a_lz;
    logic [1:0]  r_a_id;
    logic        r_b_valid;

    logic        w_b_load;
    logic        w_a_load;
    logic        w_found;
    logic        w_acc;
    logic [1:0]  w_gnt_id;
    logic [1:0]  w_next_ptr;
    logic [11:0] w_din;
    logic        w_sign;
    logic [10:0] w_mag;
    logic [3:0]  w_lz;
    logic [2:0]  w_e;
    logic [3:0]  w_f;
    logic [4:0]  w_sh;
    logic        w_rbit;
    logic [4:0]  w_fr;
    logic [2:0]  w_e_o;
    logic [3:0]  w_f_o;

    assign w_b_load = !r_b_valid || out_ready;
    assign w_a_load = (!r_a_valid || w_b_load) && !rst;
    assign w_acc    = w_found && w_a_load;

    // Search from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        logic [2:0] idx;
        logic [1:0] sel;
        w_found  = 1'b0;
        w_gnt_id = 2'd0;
        idx      = 3'd0;
        sel      = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, r_ptr} + 3'(k);
            if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
            sel = idx[1:0];
            if (!w_found && (|(req_valid & (NREQ'(1) << sel)))) begin
                w_found  = 1'b1;
                w_gnt_id = sel;
            end
        end
    end

    always_comb begin
        w_din = 12'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == 2'(i)) w_din = req_data[12*i +: 12];
        end
    end

    assign req_ready  = w_acc ? (NREQ'(1) << w_gnt_id) : '0;
    assign w_next_ptr = (w_gnt_id == 2'(NREQ-1)) ? 2'd0 : w_gnt_id + 2'd1;

    // -2048 has no positive 11-bit counterpart, so it saturates to full scale.
    always_comb begin
        w_sign = w_din[11];
        if (w_din == 12'h800)
            w_mag = 11'h7FF;
        else if (w_sign)
            w_mag = ~w_din[10:0] + 11'd1;
        else
            w_mag = w_din[10:0];
        w_lz = 4'd11;
        for (int b = 0; b <= 10; b++) begin
            if (w_mag[b]) w_lz = 4'(10 - b);
        end
    end

    always_comb begin
        if (r_a_lz <= 4'd6) begin
            w_e    = 3'(4'd7 - r_a_lz);
            w_sh   = 5'(r_a_mag >> (w_e - 3'd1));
            w_rbit = w_sh[0];
            w_f    = w_sh[4:1];
        end else begin
            w_e    = 3'd0;
            w_sh   = 5'd0;
            w_rbit = 1'b0;
            w_f    = r_a_mag[3:0];
        end
        w_fr = {1'b0, w_f} + 5'(w_rbit && ROUND_EN);
        if (w_fr[4]) begin
            if (w_e == 3'd7) begin
                w_e_o = 3'd7;
                w_f_o = 4'd15;
            end else begin
                w_e_o = w_e + 3'd1;
                w_f_o = 4'd8;
            end
        end else begin
            w_e_o = w_e;
            w_f_o = w_fr[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= 2'd0;
            r_a_valid <= 1'b0;
            r_a_sign  <= 1'b0;
            r_a_mag   <= 11'd0;
            r_a_lz    <= 4'd0;
            r_a_id    <= 2'd0;
            r_b_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= 3'd0;
            out_sig   <= 4'd0;
            out_id    <= 2'd0;
        end else begin
            if (w_a_load) begin
                r_a_valid <= w_acc;
                if (w_acc) begin
                    r_a_sign <= w_sign;
                    r_a_mag  <= w_mag;
                    r_a_lz   <= w_lz;
                    r_a_id   <= w_gnt_id;
                    r_ptr    <= w_next_ptr;
                end
            end
            if (w_b_load) begin
                r_b_valid <= r_a_valid;
                if (r_a_valid) begin
                    out_sign <= r_a_sign;
                    out_exp  <= w_e_o;
                    out_sig  <= w_f_o;
                    out_id   <= r_a_id;
                end
            end
        end
    end

    assign out_valid = r_b_valid;
    assign busy      = r_a_valid || r_b_valid;

endmodule

// File: doc/fpcvt_arb.md
Name: fpcvt_arb

Overview:
- Shares one pipelined linear-to-floating-point conversion datapath among NREQ requesters.
- Each requester presents a 12-bit two's-complement sample with a valid/ready handshake. A round-robin arbiter picks one per cycle.
- The block converts the sample to 8-bit FP (sign, 3-bit exponent, 4-bit significand, with rounding) and returns the result tagged with the requester ID on a single output stream that accepts backpressure.
- Sits between the sample sources and the FP packing/consumer logic.

Parameters:
- NREQ, 4, number of requesters; legal range 1..4. The ID field is always 2 bits.
- ROUND_EN, 1, 1 = round to nearest on the first dropped bit; 0 = truncate.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester sample valid.
- req_data  in  12*NREQ  per-requester two's-complement sample; requester i owns bits [12*i+11:12*i].
- req_ready  out  NREQ  one-hot grant/accept. Transfer occurs when req_valid[i] and req_ready[i] are both high.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_sign  out  1  sign of the result.
- out_exp  out  3  exponent E.
- out_sig  out  4  significand F. Represented value is F * 2^E.
- out_id  out  2  index of the source requester.
- busy  out  1  high when any pipeline stage holds data.

Behaviour:
- Reset (rst high at a clock edge):
  - out_valid=0, req_ready=0, busy=0.
  - out_sign/exp/sig/id = 0.
  - Round-robin pointer = 0.
  - Stage contents are discarded, including mid-flight data.
  - Reset overrides all other events on the same edge.
- Pipeline: two registered stages, A (capture + magnitude/leading-zero) then B (round + pack = output register).
  - Latency is 2 cycles from the accept edge to out_valid high, with no stall.
  - Throughput is 1 sample per cycle.
- Advance rule: B may load when B is empty or out_ready=1. A may load when A is empty or A advances into B.
- req_ready is combinational from req_valid, the pointer and the advance rule:
  - At most one bit is high.
  - All bits are 0 when A cannot load.
  - It never depends on out_ready except through the advance rule.
- Arbitration:
  - The candidate is the first i with req_valid[i], searching from pointer to NREQ-1, then wrapping to 0.
  - On an accept from requester g, pointer = (g+1) mod NREQ.
  - With no accept, the pointer holds.
  - A continuously requesting source is served at least once every NREQ accepts.
- Conversion of sample D:
  - S = D[11].
  - M = |D| in 11 bits; D = -2048 saturates to M = 2047.
  - L = count of leading zeros of M[10:0] (0..11).
  - If L <= 6: E = 7-L and F = M[E+3:E]. Otherwise E = 0 and F = M[3:0].
  - Rounding (ROUND_EN=1 and E>0): add M[E-1] to F.
    - If F overflows to 16: F = 8, E = E+1.
    - If E was already 7: saturate to E=7, F=15.
  - Zero input gives S=0, E=0, F=0.
- Stall hold: while out_valid=1 and out_ready=0, all out_* hold stable. Stage A holds its sample, and req_ready drops once A is also occupied.
- Simultaneous accept and output retire in the same cycle is legal and loses no data.
- Requester inputs that are not granted are ignored. A requester may drop req_valid at any time without effect.
- busy = A occupied OR B occupied.

Test Plan:
- Single requester 0, D=12'd422, out_ready=1 → out_valid exactly 2 cycles after accept; S=0, E=5, F=13, id=0.
- Rounding on requester 1 (pipelined):
  - D=12'd46 → E=2, F=12.
  - D=12'd62 → E=3, F=8 (significand overflow).
  - D=12'd5 → E=0, F=5.
- Saturation:
  - D=12'h7FF → S=0, E=7, F=15.
  - D=12'h800 → S=1, E=7, F=15.
  - D=12'h000 → S=0, E=0, F=0.
  - D=12'hFFB (-5) → S=1, E=0, F=5.
- All 4 requesters valid continuously, out_ready=1 → grants 0,1,2,3,0,… one per cycle; out_id follows the same order 2 cycles later.
- Backpressure: out_ready=0 for 5 cycles while 3 requests are pending → at most 2 accepts total; outputs frozen; req_ready all 0 once full. On out_ready=1, results drain in order with no loss or duplication.
- rst asserted with both stages full → next cycle out_valid=0, busy=0, pointer=0. The first post-reset grant with all valid goes to requester 0.
